// File: rtl/bus_master_pkg.sv
// Shared definitions for the byte-wide memory bus initiator: FSM state
// encoding and the width of the wait-state counter.
package bus_master_pkg;

  // Wide enough for the largest legal WAIT_CYCLES value (15).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    HOLD     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter that times the strobe phase of a bus cycle.
// It saturates at zero and flags zero so the FSM knows when the strobe ends.
module bus_wait_counter
  import bus_master_pkg::*;
(
  input  logic             clock,
  input  logic             reset_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock or negedge reset_) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs before any of them update on the same edge.
    if (!reset_) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_master.sv
// Synchronous initiator for the asynchronous byte-wide memory bus.
// Accepts one request via soc/eoc, then runs setup, strobe (with
// WAIT_CYCLES wait states) and hold phases on addr/d7_d0/s_/mr_/mw_.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              soc,
  output logic              eoc,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        d7_d0,
  output logic              s_,
  output logic              mr_,
  output logic              mw_
);

  // The counter is loaded on the SETUP->STROBE edge, so the strobe lasts
  // WAIT_CYCLES edges when the load value is one less.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t     state;
  logic       rw_q;
  logic [7:0] wdata_q;
  logic       drive_en;
  logic       cnt_zero;

  bus_wait_counter u_wait_counter (
    .clock      (clock),
    .reset_     (reset_),
    .load       (state == SETUP),
    .load_value (WAIT_LOAD),
    .dec        (state == STROBE),
    .zero       (cnt_zero)
  );

  // The bus data lines carry the latched write byte from SETUP through
  // HOLD; the reset term of drive_en releases them asynchronously.
  assign d7_d0 = drive_en ? wdata_q : 8'hzz;

  // Bus-cycle sequencer; every bus-facing output is a register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      eoc      <= 1'b1;
      s_       <= 1'b1;
      mr_      <= 1'b1;
      mw_      <= 1'b1;
      addr     <= '0;
      data_out <= '0;
      drive_en <= 1'b0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (soc) begin
            rw_q     <= rw;
            addr     <= addr_in;
            wdata_q  <= data_in;
            s_       <= 1'b0;
            eoc      <= 1'b0;
            drive_en <= ~rw;
            state    <= SETUP;
          end
        end
        SETUP: begin
          mr_   <= ~rw_q;
          mw_   <= rw_q;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt_zero) begin
            if (rw_q) begin
              data_out <= d7_d0;
            end
            mr_   <= 1'b1;
            mw_   <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          s_       <= 1'b1;
          drive_en <= 1'b0;
          eoc      <= 1'b1;
          state    <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // A held-high soc must drop for one edge before another cycle.
          if (!soc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: a transaction-level reference model
// (cycle offsets from request acceptance plus a byte-array memory) drives a
// per-cycle compare process; directed scenarios add literal expectations.
module tb_bus_master;

  localparam int W  = 2;
  localparam int W1 = 1;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        soc = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic        eoc, s_, mr_, mw_;
  logic [7:0]  data_out;
  logic [15:0] addr;
  wire  [7:0]  d7_d0;

  logic        soc1 = 1'b0;
  logic        rw1 = 1'b1;
  logic [15:0] addr_in1 = '0;
  logic [7:0]  data_in1 = '0;
  logic        eoc1, s1_, mr1_, mw1_;
  logic [7:0]  data_out1;
  logic [15:0] addr1;
  wire  [7:0]  d7_d0_1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bus_master #(.ADDR_W(16), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset_(reset_), .soc(soc), .eoc(eoc), .rw(rw),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
    .addr(addr), .d7_d0(d7_d0), .s_(s_), .mr_(mr_), .mw_(mw_)
  );

  bus_master #(.ADDR_W(16), .WAIT_CYCLES(W1)) dut1 (
    .clock(clock), .reset_(reset_), .soc(soc1), .eoc(eoc1), .rw(rw1),
    .addr_in(addr_in1), .data_in(data_in1), .data_out(data_out1),
    .addr(addr1), .d7_d0(d7_d0_1), .s_(s1_), .mr_(mr1_), .mw_(mw1_)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Responder RAM on the main bus: read data appears 3 time units after
  // the strobe, writes commit on the rising edge of mw_.
  logic [7:0] ram [0:65535];
  logic       bus_live = 1'b0;
  logic       rd_en;
  assign #3 rd_en = !s_ && !mr_;
  assign d7_d0 = rd_en ? ram[addr] : 8'hzz;
  pullup (d7_d0);
  always @(posedge mw_) if (bus_live && !s_) ram[addr] = d7_d0;

  // Read-only responder on the second bus with a half-period access delay.
  logic rd1_en;
  assign #5 rd1_en = !s1_ && !mr1_;
  assign d7_d0_1 = rd1_en ? init_byte(addr1) : 8'hzz;
  pullup (d7_d0_1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is accepted on an edge while ready and soc=1;
  // m_j counts edges since acceptance. After W+2 edges the cycle is done
  // and soc must be seen low on an edge before the next one is accepted.
  logic [7:0]  model_mem [0:65535];
  bit          m_active, m_armed;
  int          m_j;
  logic        m_rw;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_dout;

  always @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      m_active = 1'b0;
      m_armed  = 1'b1;
      m_j      = 0;
      m_dout   = 8'h00;
    end else if (m_active) begin
      m_j++;
      if (m_j == W + 1) begin
        if (m_rw) m_dout = model_mem[m_addr];
        else      model_mem[m_addr] = m_wdata;
      end
      if (m_j == W + 2) begin
        m_active = 1'b0;
        m_armed  = 1'b0;
      end
    end else if (!m_armed) begin
      if (!soc) m_armed = 1'b1;
    end else if (soc) begin
      m_active = 1'b1;
      m_j      = 0;
      m_rw     = rw;
      m_addr   = addr_in;
      m_wdata  = data_in;
    end
  end

  // Per-cycle compare of the main bus against the model.
  logic exp_strobe;
  always @(negedge clock) begin
    if (reset_) begin
      exp_strobe = m_active && (m_j >= 1) && (m_j <= W);
      check("eoc", 32'(eoc), 32'(!m_active));
      check("s_", 32'(s_), 32'(!m_active));
      check("mr_", 32'(mr_), 32'(!(exp_strobe && m_rw)));
      check("mw_", 32'(mw_), 32'(!(exp_strobe && !m_rw)));
      check("data_out", 32'(data_out), 32'(m_dout));
      if (m_active) check("addr", 32'(addr), 32'(m_addr));
      if (m_active && !m_rw) check("d7_d0_write", 32'(d7_d0), 32'(m_wdata));
      else if (!m_active)    check("d7_d0_released", 32'(d7_d0), 32'hFF);
    end
  end

  // Free-running measurements used by the directed checks.
  int     cnt_mw_low = 0, cnt_eoc_low = 0, cnt_eoc1_low = 0, cnt_strobe_fall = 0;
  longint t_s_fall, t_s_rise, t_mr_fall, t_mr_rise;
  always @(negedge clock) begin
    if (!mw_)  cnt_mw_low++;
    if (!eoc)  cnt_eoc_low++;
    if (!eoc1) cnt_eoc1_low++;
  end
  always @(negedge mr_ or negedge mw_) cnt_strobe_fall++;
  always @(negedge s_)  t_s_fall  = $time;
  always @(posedge s_)  t_s_rise  = $time;
  always @(negedge mr_) t_mr_fall = $time;
  always @(posedge mr_) t_mr_rise = $time;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // One request on the main bus; soc stays high for 'hold' edges, inputs
  // are optionally corrupted right after acceptance, then the bench waits
  // for eoc and gives one soc-low edge so the master returns to IDLE.
  task automatic do_txn(input logic r, input logic [15:0] a, input logic [7:0] d,
                        input int hold, input bit scramble);
    rw = r; addr_in = a; data_in = d; soc = 1'b1;
    tick();
    if (scramble) begin
      addr_in = 16'hFFFF; data_in = 8'h00; rw = ~r;
    end
    repeat (hold - 1) tick();
    soc = 1'b0;
    for (int i = 0; i < 40 && eoc !== 1'b1; i++) tick();
    check("eoc_return", 32'(eoc), 32'h1);
    tick();
  endtask

  task automatic do_read1(input logic [15:0] a);
    int snap;
    snap = cnt_eoc1_low;
    addr_in1 = a; rw1 = 1'b1; soc1 = 1'b1;
    tick();
    soc1 = 1'b0;
    for (int i = 0; i < 40 && eoc1 !== 1'b1; i++) tick();
    tick();
    check("w1_eoc_low_cycles", 32'(cnt_eoc1_low - snap), 32'd3);
    check("w1_read_data", 32'(data_out1), 32'(init_byte(a)));
  endtask

  initial begin
    int snap, snap2;
    for (int i = 0; i < 65536; i++) begin
      ram[i]       = init_byte(16'(i));
      model_mem[i] = init_byte(16'(i));
    end
    repeat (2) tick();
    check("rst_eoc", 32'(eoc), 32'h1);
    check("rst_s_", 32'(s_), 32'h1);
    check("rst_mr_", 32'(mr_), 32'h1);
    check("rst_mw_", 32'(mw_), 32'h1);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_d7_d0", 32'(d7_d0), 32'hFF);
    reset_ = 1'b1;
    bus_live = 1'b1;
    tick();

    // Write then read back, with strobe width measured.
    snap = cnt_mw_low;
    do_txn(1'b0, 16'h1234, 8'hA5, 1, 1'b0);
    check("mw_low_cycles", 32'(cnt_mw_low - snap), 32'd2);
    do_txn(1'b1, 16'h1234, 8'h00, 1, 1'b0);
    check("readback_1234", 32'(data_out), 32'hA5);

    // Read at 0: eoc busy time and s_/mr_ framing.
    snap = cnt_eoc_low;
    do_txn(1'b1, 16'h0000, 8'h00, 1, 1'b0);
    check("eoc_low_cycles", 32'(cnt_eoc_low - snap), 32'd4);
    check("s_lead_mr_", 32'(t_mr_fall - t_s_fall), 32'd10);
    check("s_lag_mr_", 32'(t_s_rise - t_mr_rise), 32'd10);
    check("read_0000", 32'(data_out), 32'h5A);

    // soc held high for 10 edges: exactly one bus cycle.
    snap = cnt_strobe_fall;
    rw = 1'b1; addr_in = 16'h0101; soc = 1'b1;
    repeat (10) tick();
    check("held_soc_eoc_idle", 32'(eoc), 32'h1);
    check("held_soc_one_cycle", 32'(cnt_strobe_fall - snap), 32'd1);
    soc = 1'b0;
    tick();

    // Inputs corrupted during the cycle must be ignored.
    do_txn(1'b0, 16'h0010, 8'h3C, 1, 1'b1);
    check("ram_0010", 32'(ram[16'h0010]), 32'h3C);
    check("ram_ffff_untouched", 32'(ram[16'hFFFF]), 32'h5A);
    do_txn(1'b1, 16'h0010, 8'h00, 1, 1'b0);
    check("readback_0010", 32'(data_out), 32'h3C);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)),
             8'($urandom_range(0, 254)), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a write strobe.
    rw = 1'b0; addr_in = 16'h0200; data_in = 8'h77; soc = 1'b1;
    tick();
    soc = 1'b0;
    tick();
    check("pre_reset_mw_low", 32'(mw_), 32'h0);
    snap2 = 0;
    reset_ = 1'b0;
    #1;
    check("midrst_s_", 32'(s_), 32'h1);
    check("midrst_mr_", 32'(mr_), 32'h1);
    check("midrst_mw_", 32'(mw_), 32'h1);
    check("midrst_d7_d0", 32'(d7_d0), 32'hFF);
    check("midrst_eoc", 32'(eoc), 32'h1);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_addr", 32'(addr), 32'h0);
    tick();
    reset_ = 1'b1;
    tick();
    do_txn(1'b1, 16'h0103, 8'h00, 2, 1'b0);

    // WAIT_CYCLES = 1 instance against a half-period responder.
    do_read1(16'h1234);
    check("w1_read_1234_literal", 32'(data_out1), 32'h7C);
    do_read1(16'hABCD);
    do_read1(16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
